// File: rtl/s2p_frame_deser.sv
// Serial-to-parallel frame deserializer for the column ADC readout link.
// Shifts NUM_CH words of BITS_ADC bits in while data_valid is low and publishes each complete frame atomically.
module s2p_frame_deser #(
    parameter int unsigned BITS_ADC  = 12,
    parameter int unsigned NUM_CH    = 32,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned CH_W     = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_data,
    input  logic                         data_valid,
    output logic                         word_valid,
    output logic [BITS_ADC-1:0]          word_data,
    output logic [CH_W-1:0]              word_ch,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic [ERR_CNT_W-1:0]         err_cnt,
    output logic [NUM_CH*BITS_ADC-1:0]   data_out
);

    localparam int unsigned BIT_W = (BITS_ADC > 1) ? $clog2(BITS_ADC) : 1;
    localparam int unsigned FW    = NUM_CH * BITS_ADC;

    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]      ch_cnt_q, ch_cnt_d;
    logic [BITS_ADC-1:0]  sr_q, sr_d, sr_shift;
    logic [FW-1:0]        bank_q, bank_d;
    logic [FW-1:0]        data_out_q, data_out_d;
    logic                 word_valid_q, word_valid_d;
    logic [BITS_ADC-1:0]  word_data_q, word_data_d;
    logic [CH_W-1:0]      word_ch_q, word_ch_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 last_bit, last_ch;

    assign last_bit = (bit_cnt_q == BIT_W'(BITS_ADC - 1));
    assign last_ch  = (ch_cnt_q == CH_W'(NUM_CH - 1));

    // Next-state: shift, word/frame completion, abort and idle hold.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        ch_cnt_d     = ch_cnt_q;
        sr_d         = sr_q;
        bank_d       = bank_q;
        data_out_d   = data_out_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        word_ch_d    = word_ch_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        sr_shift     = LSB_FIRST ? {s_data, sr_q[BITS_ADC-1:1]} : {sr_q[BITS_ADC-2:0], s_data};

        if (!data_valid) begin
            sr_d = sr_shift;
            if (last_bit) begin
                bit_cnt_d    = '0;
                word_valid_d = 1'b1;
                word_data_d  = sr_shift;
                word_ch_d    = ch_cnt_q;
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (ch_cnt_q == CH_W'(k)) begin
                        bank_d[k*BITS_ADC +: BITS_ADC] = sr_shift;
                    end
                end
                if (last_ch) begin
                    ch_cnt_d     = '0;
                    frame_done_d = 1'b1;
                    data_out_d   = bank_d;
                end else begin
                    ch_cnt_d = ch_cnt_q + CH_W'(1);
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
        end else if ((bit_cnt_q != '0) || (ch_cnt_q != '0)) begin
            bit_cnt_d   = '0;
            ch_cnt_d    = '0;
            frame_err_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            sr_q         <= '0;
            bank_q       <= '0;
            data_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_ch_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            ch_cnt_q     <= ch_cnt_d;
            sr_q         <= sr_d;
            bank_q       <= bank_d;
            data_out_q   <= data_out_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_ch_q    <= word_ch_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_ch    = word_ch_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_s2p_frame_deser.sv
// Directed bench for s2p_frame_deser: default LSB-first instance, an MSB-first instance
// and a 2-bit error-counter instance, all sharing one stimulus stream.
module tb_s2p_frame_deser;

    localparam int unsigned BA = 12;
    localparam int unsigned NC = 32;
    localparam int unsigned FW = BA * NC;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic s_data = 1'b0;
    logic data_valid = 1'b1;

    logic          m_word_valid, m_frame_done, m_frame_err;
    logic [BA-1:0] m_word_data;
    logic [4:0]    m_word_ch;
    logic [7:0]    m_err_cnt;
    logic [FW-1:0] m_data_out;

    logic          b_word_valid, b_frame_done, b_frame_err;
    logic [BA-1:0] b_word_data;
    logic [4:0]    b_word_ch;
    logic [7:0]    b_err_cnt;
    logic [FW-1:0] b_data_out;

    logic          e_word_valid, e_frame_done, e_frame_err;
    logic [BA-1:0] e_word_data;
    logic [4:0]    e_word_ch;
    logic [1:0]    e_err_cnt;
    logic [FW-1:0] e_data_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    int done_cyc = 0;

    s2p_frame_deser dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .data_valid(data_valid),
        .word_valid(m_word_valid), .word_data(m_word_data), .word_ch(m_word_ch),
        .frame_done(m_frame_done), .frame_err(m_frame_err), .err_cnt(m_err_cnt),
        .data_out(m_data_out)
    );

    s2p_frame_deser #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .data_valid(data_valid),
        .word_valid(b_word_valid), .word_data(b_word_data), .word_ch(b_word_ch),
        .frame_done(b_frame_done), .frame_err(b_frame_err), .err_cnt(b_err_cnt),
        .data_out(b_data_out)
    );

    s2p_frame_deser #(.ERR_CNT_W(2)) dut_err (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .data_valid(data_valid),
        .word_valid(e_word_valid), .word_data(e_word_data), .word_ch(e_word_ch),
        .frame_done(e_frame_done), .frame_err(e_frame_err), .err_cnt(e_err_cnt),
        .data_out(e_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // One stimulus cycle: drive on falling edge, observe 1 time unit after the rising edge.
    task automatic cyc(input logic dv, input logic b);
        @(negedge clk);
        data_valid = dv;
        s_data     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        data_valid = 1'b1;
        s_data     = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Streams frame f LSB-first and checks every cycle; prev is data_out expected before completion.
    task automatic run_frame(input logic [FW-1:0] f, input logic [FW-1:0] prev, input string tag);
        logic [BA-1:0] w;
        logic exp_last, exp_done;
        for (int k = 0; k < NC; k++) begin
            w = f[k*BA +: BA];
            for (int i = 0; i < BA; i++) begin
                cyc(1'b0, w[i]);
                exp_last = (i == BA - 1);
                exp_done = exp_last && (k == NC - 1);
                vectors++;
                if (m_word_valid !== exp_last) begin
                    miscompares++;
                    $display("FAIL %s word_valid k=%0d i=%0d got %b want %b", tag, k, i, m_word_valid, exp_last);
                end
                if (exp_last) begin
                    vectors++;
                    if (m_word_data !== w) begin
                        miscompares++;
                        $display("FAIL %s word_data k=%0d got %h want %h", tag, k, m_word_data, w);
                    end
                    vectors++;
                    if (m_word_ch !== 5'(k)) begin
                        miscompares++;
                        $display("FAIL %s word_ch k=%0d got %0d want %0d", tag, k, m_word_ch, k);
                    end
                end
                vectors++;
                if (m_frame_done !== exp_done) begin
                    miscompares++;
                    $display("FAIL %s frame_done k=%0d i=%0d got %b want %b", tag, k, i, m_frame_done, exp_done);
                end
                vectors++;
                if (m_frame_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s frame_err k=%0d i=%0d got %b want 0", tag, k, i, m_frame_err);
                end
                vectors++;
                if (m_data_out !== (exp_done ? f : prev)) begin
                    miscompares++;
                    $display("FAIL %s data_out k=%0d i=%0d got %h want %h", tag, k, i, m_data_out, exp_done ? f : prev);
                end
                if (exp_done) done_cyc = cyc_n;
            end
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input int base, input int step);
        logic [FW-1:0] f;
        for (int k = 0; k < NC; k++) f[k*BA +: BA] = 12'(base + k * step);
        return f;
    endfunction

    task automatic test_reset;
        do_reset();
        #1;
        vectors++;
        if ({m_word_valid, m_frame_done, m_frame_err} !== 3'b000 || m_word_data !== '0 || m_word_ch !== '0) begin
            miscompares++;
            $display("FAIL reset_outs got wv=%b fd=%b fe=%b wd=%h wc=%0d want all 0",
                     m_word_valid, m_frame_done, m_frame_err, m_word_data, m_word_ch);
        end
        vectors++;
        if (m_data_out !== '0 || m_err_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_state got err_cnt=%0d data_out=%h want 0", m_err_cnt, m_data_out);
        end
        for (int n = 0; n < 3; n++) begin
            cyc(1'b1, 1'b1);
            vectors++;
            if ({m_word_valid, m_frame_done, m_frame_err} !== 3'b000 || m_err_cnt !== '0) begin
                miscompares++;
                $display("FAIL idle_hold n=%0d got wv=%b fd=%b fe=%b err=%0d want 0",
                         n, m_word_valid, m_frame_done, m_frame_err, m_err_cnt);
            end
        end
    endtask

    task automatic test_full_frame;
        run_frame(mk_frame(12'h100, 1), '0, "frame1");
        cyc(1'b1, 1'b0);
        vectors++;
        if (m_frame_err !== 1'b0 || m_data_out !== mk_frame(12'h100, 1)) begin
            miscompares++;
            $display("FAIL post_frame_idle got fe=%b data_out=%h want 0 / frame1", m_frame_err, m_data_out);
        end
    endtask

    task automatic test_back_to_back;
        logic [FW-1:0] f1;
        int t1;
        f1 = mk_frame(12'h100, 1);
        run_frame(f1, f1, "b2b_a");
        t1 = done_cyc;
        run_frame(~f1, f1, "b2b_b");
        vectors++;
        if (done_cyc - t1 !== 384) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d want 384", done_cyc - t1);
        end
    endtask

    task automatic test_abort;
        logic [FW-1:0] prev, f3;
        prev = ~mk_frame(12'h100, 1);
        f3   = mk_frame(3, 37);
        for (int n = 0; n < 5 * BA + 8; n++) cyc(1'b0, f3[n]);
        vectors++;
        if (m_frame_err !== 1'b0 || m_data_out !== prev) begin
            miscompares++;
            $display("FAIL abort_pre got fe=%b data_out=%h want 0 / %h", m_frame_err, m_data_out, prev);
        end
        cyc(1'b1, 1'b0);
        vectors++;
        if (m_frame_err !== 1'b1 || m_err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL abort_pulse got fe=%b err_cnt=%0d want 1 / 1", m_frame_err, m_err_cnt);
        end
        vectors++;
        if (m_frame_done !== 1'b0 || m_word_valid !== 1'b0 || m_data_out !== prev) begin
            miscompares++;
            $display("FAIL abort_hold got fd=%b wv=%b data_out=%h want 0 0 %h", m_frame_done, m_word_valid, m_data_out, prev);
        end
        cyc(1'b1, 1'b0);
        vectors++;
        if (m_frame_err !== 1'b0 || m_err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL abort_one_shot got fe=%b err_cnt=%0d want 0 / 1", m_frame_err, m_err_cnt);
        end
        run_frame(f3, prev, "after_abort");
    endtask

    task automatic test_msb_first;
        logic [BA-1:0] w;
        w = 12'hA5C;
        do_reset();
        for (int i = BA - 1; i >= 0; i--) begin
            cyc(1'b0, w[i]);
            vectors++;
            if (b_word_valid !== (i == 0)) begin
                miscompares++;
                $display("FAIL msb_word_valid i=%0d got %b want %b", i, b_word_valid, (i == 0));
            end
        end
        vectors++;
        if (b_word_data !== 12'hA5C || b_word_ch !== 5'd0) begin
            miscompares++;
            $display("FAIL msb_word got %h ch %0d want a5c ch 0", b_word_data, b_word_ch);
        end
        vectors++;
        if (m_word_data !== 12'h3A5) begin
            miscompares++;
            $display("FAIL lsb_view_of_msb_stream got %h want 3a5", m_word_data);
        end
        cyc(1'b1, 1'b0);
    endtask

    task automatic test_err_sat;
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < 3; n++) cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b0);
            vectors++;
            if (e_frame_err !== 1'b1 || e_err_cnt !== exp_seq[r]) begin
                miscompares++;
                $display("FAIL err_sat r=%0d got fe=%b cnt=%0d want 1 / %0d", r, e_frame_err, e_err_cnt, exp_seq[r]);
            end
            cyc(1'b1, 1'b0);
        end
        vectors++;
        if (m_err_cnt !== 8'd5) begin
            miscompares++;
            $display("FAIL err_cnt_wide got %0d want 5", m_err_cnt);
        end
    endtask

    task automatic test_mid_reset;
        logic [FW-1:0] f1;
        f1 = mk_frame(12'h100, 1);
        do_reset();
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        run_frame(f1, '0, "pre_reset");
        for (int n = 0; n < 20 * BA + 5; n++) cyc(1'b0, ~f1[n]);
        vectors++;
        if (m_data_out !== f1 || m_err_cnt !== 8'd1 || m_word_data !== ~f1[19*BA +: BA]) begin
            miscompares++;
            $display("FAIL mid_pre got err=%0d wd=%h want 1 / %h", m_err_cnt, m_word_data, ~f1[19*BA +: BA]);
        end
        @(negedge clk);
        data_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (m_data_out !== '0 || m_err_cnt !== '0 || m_word_data !== '0 || m_word_ch !== '0) begin
            miscompares++;
            $display("FAIL async_reset got err=%0d wd=%h wc=%0d data_out=%h want 0", m_err_cnt, m_word_data, m_word_ch, m_data_out);
        end
        vectors++;
        if ({m_word_valid, m_frame_done, m_frame_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset_pulses got %b want 000", {m_word_valid, m_frame_done, m_frame_err});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(~f1, '0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_abort();
        test_msb_first();
        test_err_sat();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
